bpu_gshare: RTL and testbench

- Parametrised successor of the core's decode-stage branch predictor.
- Predicts direction and target for JAL and B-type instructions in the same cycle they are presented.
- Direction mode is selectable at run time: never-taken, static BTFN, bimodal, or gshare (global history XOR PC).
- Trained non-speculatively from execute, and keeps prediction/misprediction statistics for performance evaluation.

---
 rtl/bpu_gshare.sv | 130 +++++++++++++
 tb/tb_bpu_gshare.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_gshare.sv
// Decode-stage branch predictor: JAL/B-type target plus selectable direction
// (never-taken, BTFN, bimodal, gshare), trained from execute, with statistics.
module bpu_gshare #(
   parameter int IDX_W  = 5,
   parameter int HIST_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst_i,
   input  logic [31:0]      inst_addr_i,
   input  logic [1:0]       mode_i,
   output logic             bp_result_o,
   output logic [31:0]      bp_jump_addr_o,
   output logic [IDX_W-1:0] bp_idx_o,
   input  logic             upd_valid_i,
   input  logic [31:0]      upd_addr_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i,
   input  logic             upd_mispred_i,
   input  logic             pred_valid_i,
   input  logic             clr_stats_i,
   output logic [CNT_W-1:0] pred_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam int         N      = 1 << IDX_W;

   logic [1:0]        bht [N];
   logic [1:0]        pht [N];
   logic [HIST_W-1:0] ghr;
   logic [HIST_W-1:0] ghr_next;

   logic              is_jal;
   logic              is_br;
   logic [31:0]       imm_j;
   logic [31:0]       imm_b;
   logic [31:0]       tgt_j;
   logic [31:0]       tgt_b;
   logic [IDX_W-1:0]  bht_idx;
   logic [IDX_W-1:0]  upd_bht_idx;
   logic              dir;

   wire unused_addr = &{1'b0, upd_addr_i[31:IDX_W+2], upd_addr_i[1:0]};

   function automatic logic [1:0] step(input logic [1:0] c, input logic t);
      if (t) return (c == 2'b11) ? c : c + 2'd1;
      else   return (c == 2'b00) ? c : c - 2'd1;
   endfunction

   assign is_jal = (inst_i[6:0] == OP_JAL);
   assign is_br  = (inst_i[6:0] == OP_BR);

   assign imm_j = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20],
                   inst_i[30:21], 1'b0};
   assign imm_b = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25],
                   inst_i[11:8], 1'b0};
   assign tgt_j = inst_addr_i + imm_j;
   assign tgt_b = inst_addr_i + imm_b;

   assign bht_idx     = inst_addr_i[IDX_W+1:2];
   assign upd_bht_idx = upd_addr_i[IDX_W+1:2];
   assign bp_idx_o    = bht_idx ^ IDX_W'(ghr);

   always_comb begin
      dir = 1'b0;
      unique case (mode_i)
         2'd0:    dir = 1'b0;
         2'd1:    dir = ($signed(tgt_b) < $signed(inst_addr_i));
         2'd2:    dir = bht[bht_idx][1];
         2'd3:    dir = pht[bp_idx_o][1];
         default: dir = 1'b0;
      endcase
   end

   always_comb begin
      bp_result_o    = 1'b0;
      bp_jump_addr_o = 32'd0;
      if (is_jal) begin
         bp_result_o    = 1'b1;
         bp_jump_addr_o = tgt_j;
      end else if (is_br) begin
         bp_result_o    = dir;
         bp_jump_addr_o = tgt_b;
      end
   end

   // Separate arrays, so equal bht/pht indices never collide.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            bht[i] <= 2'b10;
            pht[i] <= 2'b10;
         end
      end else if (upd_valid_i) begin
         bht[upd_bht_idx] <= step(bht[upd_bht_idx], upd_taken_i);
         pht[upd_idx_i]   <= step(pht[upd_idx_i], upd_taken_i);
      end
   end

   generate
      if (HIST_W == 1) begin : g_hist1
         assign ghr_next = upd_taken_i;
      end else begin : g_histn
         assign ghr_next = {ghr[HIST_W-2:0], upd_taken_i};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst)              ghr <= '0;
      else if (upd_valid_i) ghr <= ghr_next;
   end

   always_ff @(posedge clk) begin
      if (rst || clr_stats_i)
         pred_cnt_o <= '0;
      else if (pred_valid_i && is_br && pred_cnt_o != '1)
         pred_cnt_o <= pred_cnt_o + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst || clr_stats_i)
         mispred_cnt_o <= '0;
      else if (upd_valid_i && upd_mispred_i && mispred_cnt_o != '1)
         mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
   end

endmodule

// File: tb/tb_bpu_gshare.sv
// Directed bench for bpu_gshare: targets, direction modes, training,
// same-cycle update, statistics and saturation (second instance, CNT_W=4).
module tb_bpu_gshare;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [1:0]  mode;
   logic        upd_valid;
   logic [31:0] upd_addr;
   logic [4:0]  upd_idx;
   logic        upd_taken;
   logic        upd_mispred;
   logic        pred_valid;
   logic        clr_stats;

   logic        result;
   logic [31:0] jaddr;
   logic [4:0]  idx;
   logic [31:0] pcnt;
   logic [31:0] mcnt;

   logic        s_result;
   logic [31:0] s_jaddr;
   logic [4:0]  s_idx;
   logic [3:0]  s_pcnt;
   logic [3:0]  s_mcnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bpu_gshare u_dut (
      .clk(clk), .rst(rst), .inst_i(inst), .inst_addr_i(pc), .mode_i(mode),
      .bp_result_o(result), .bp_jump_addr_o(jaddr), .bp_idx_o(idx),
      .upd_valid_i(upd_valid), .upd_addr_i(upd_addr), .upd_idx_i(upd_idx),
      .upd_taken_i(upd_taken), .upd_mispred_i(upd_mispred),
      .pred_valid_i(pred_valid), .clr_stats_i(clr_stats),
      .pred_cnt_o(pcnt), .mispred_cnt_o(mcnt)
   );

   bpu_gshare #(.CNT_W(4)) u_small (
      .clk(clk), .rst(rst), .inst_i(inst), .inst_addr_i(pc), .mode_i(mode),
      .bp_result_o(s_result), .bp_jump_addr_o(s_jaddr), .bp_idx_o(s_idx),
      .upd_valid_i(upd_valid), .upd_addr_i(upd_addr), .upd_idx_i(upd_idx),
      .upd_taken_i(upd_taken), .upd_mispred_i(upd_mispred),
      .pred_valid_i(pred_valid), .clr_stats_i(clr_stats),
      .pred_cnt_o(s_pcnt), .mispred_cnt_o(s_mcnt)
   );

   function automatic logic [31:0] enc_b(input logic [31:0] off);
      return {off[12], off[10:5], 5'd0, 5'd0, 3'd0, off[4:1], off[11],
              7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] off);
      return {off[20], off[10:1], off[11], off[19:12], 5'd0, 7'b1101111};
   endfunction

   task automatic upd(input logic [31:0] a, input logic [4:0] i,
                      input logic t);
      @(negedge clk);
      upd_valid   = 1'b1;
      upd_addr    = a;
      upd_idx     = i;
      upd_taken   = t;
      upd_mispred = 1'b0;
      @(negedge clk);
      upd_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; inst = 32'h13; pc = 32'd0; mode = 2'd0;
      upd_valid = 1'b0; upd_addr = 32'd0; upd_idx = 5'd0;
      upd_taken = 1'b0; upd_mispred = 1'b0;
      pred_valid = 1'b0; clr_stats = 1'b0;
      @(negedge clk);
      @(negedge clk);
      mode = 2'd2; pc = 32'h100; inst = enc_b(-8);
      #1;
      n_checks++;
      if (result !== 1'b1) begin
         n_fail++; $display("FAIL reset_dir: got %b exp 1", result);
      end
      n_checks++;
      if (jaddr !== 32'hF8) begin
         n_fail++; $display("FAIL reset_tgt: got %h exp 000000f8", jaddr);
      end
      n_checks++;
      if (pcnt !== 32'd0 || mcnt !== 32'd0) begin
         n_fail++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", pcnt, mcnt);
      end
      n_checks++;
      if (s_pcnt !== 4'd0 || s_mcnt !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_scnt: got %0d/%0d exp 0/0", s_pcnt, s_mcnt);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_static();
      @(negedge clk);
      mode = 2'd1; pc = 32'h200; inst = enc_b(16);
      #1;
      n_checks++;
      if (result !== 1'b0 || jaddr !== 32'h210) begin
         n_fail++;
         $display("FAIL btfn_fwd: got %b %h exp 0 00000210", result, jaddr);
      end
      inst = enc_b(-16);
      #1;
      n_checks++;
      if (result !== 1'b1 || jaddr !== 32'h1F0) begin
         n_fail++;
         $display("FAIL btfn_bwd: got %b %h exp 1 000001f0", result, jaddr);
      end
      mode = 2'd0;
      #1;
      n_checks++;
      if (result !== 1'b0 || jaddr !== 32'h1F0) begin
         n_fail++;
         $display("FAIL never_taken: got %b %h exp 0 000001f0", result, jaddr);
      end
      pc = 32'd0; inst = enc_j(32'h800);
      #1;
      n_checks++;
      if (result !== 1'b1 || jaddr !== 32'h800) begin
         n_fail++;
         $display("FAIL jal_fwd: got %b %h exp 1 00000800", result, jaddr);
      end
      mode = 2'd3; pc = 32'h10; inst = enc_j(-32'h20);
      #1;
      n_checks++;
      if (result !== 1'b1 || jaddr !== 32'hFFFF_FFF0) begin
         n_fail++;
         $display("FAIL jal_wrap: got %b %h exp 1 fffffff0", result, jaddr);
      end
      inst = 32'h0000_0013;
      #1;
      n_checks++;
      if (result !== 1'b0 || jaddr !== 32'd0) begin
         n_fail++;
         $display("FAIL non_branch: got %b %h exp 0 00000000", result, jaddr);
      end
   endtask

   task automatic test_bimodal();
      upd(32'h104, 5'd31, 1'b0);
      upd(32'h104, 5'd31, 1'b0);
      mode = 2'd2; pc = 32'h104; inst = enc_b(8);
      #1;
      n_checks++;
      if (result !== 1'b0 || jaddr !== 32'h10C) begin
         n_fail++;
         $display("FAIL bim_nt2: got %b %h exp 0 0000010c", result, jaddr);
      end
      upd(32'h104, 5'd31, 1'b1);
      upd(32'h104, 5'd31, 1'b1);
      #1;
      n_checks++;
      if (result !== 1'b1) begin
         n_fail++; $display("FAIL bim_t2: got %b exp 1", result);
      end
      upd(32'h104, 5'd31, 1'b1);
      #1;
      n_checks++;
      if (result !== 1'b1) begin
         n_fail++; $display("FAIL bim_t3: got %b exp 1", result);
      end
      upd(32'h104, 5'd31, 1'b1);
      upd(32'h104, 5'd31, 1'b0);
      #1;
      n_checks++;
      if (result !== 1'b1) begin
         n_fail++; $display("FAIL bim_sat_hi: got %b exp 1", result);
      end
   endtask

   task automatic test_gshare();
      pulse_reset();
      upd(32'h7C, 5'd6, 1'b0);
      upd(32'h7C, 5'd6, 1'b0);
      upd(32'h7C, 5'd31, 1'b1);
      upd(32'h7C, 5'd31, 1'b1);
      upd(32'h7C, 5'd31, 1'b0);
      mode = 2'd3; pc = 32'h0; inst = enc_b(8);
      #1;
      n_checks++;
      if (idx !== 5'd6) begin
         n_fail++; $display("FAIL gs_idx: got %0d exp 6", idx);
      end
      n_checks++;
      if (result !== 1'b0 || jaddr !== 32'h8) begin
         n_fail++;
         $display("FAIL gs_dir: got %b %h exp 0 00000008", result, jaddr);
      end
      mode = 2'd2;
      #1;
      n_checks++;
      if (result !== 1'b1) begin
         n_fail++; $display("FAIL gs_vs_bim: got %b exp 1", result);
      end
      mode = 2'd3; pc = 32'h18;
      #1;
      n_checks++;
      if (idx !== 5'd0 || result !== 1'b1) begin
         n_fail++;
         $display("FAIL gs_idx0: got %0d %b exp 0 1", idx, result);
      end
      pc = 32'h104; inst = 32'h0000_0013;
      #1;
      n_checks++;
      if (idx !== 5'd7 || result !== 1'b0) begin
         n_fail++;
         $display("FAIL gs_idx_nonbr: got %0d %b exp 7 0", idx, result);
      end
   endtask

   task automatic test_same_cycle();
      @(negedge clk);
      mode = 2'd2; pc = 32'h7C; inst = enc_b(8);
      upd_valid = 1'b1; upd_addr = 32'h7C; upd_idx = 5'd0;
      upd_taken = 1'b1; upd_mispred = 1'b0;
      #1;
      n_checks++;
      if (result !== 1'b0) begin
         n_fail++; $display("FAIL same_cyc_pre: got %b exp 0", result);
      end
      @(negedge clk);
      upd_valid = 1'b0;
      #1;
      n_checks++;
      if (result !== 1'b1) begin
         n_fail++; $display("FAIL same_cyc_post: got %b exp 1", result);
      end
   endtask

   task automatic test_stats();
      pulse_reset();
      upd_addr = 32'h7C; upd_idx = 5'd3; upd_taken = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         pred_valid  = (i != 3);
         inst        = (i == 5) ? enc_j(8) : enc_b(8);
         upd_valid   = (i < 3);
         upd_mispred = (i != 1);
      end
      @(negedge clk);
      pred_valid = 1'b0; upd_valid = 1'b0; upd_mispred = 1'b0;
      #1;
      n_checks++;
      if (pcnt !== 32'd5 || mcnt !== 32'd2) begin
         n_fail++; $display("FAIL stats: got %0d/%0d exp 5/2", pcnt, mcnt);
      end
      n_checks++;
      if (s_pcnt !== 4'd5 || s_mcnt !== 4'd2) begin
         n_fail++;
         $display("FAIL stats_small: got %0d/%0d exp 5/2", s_pcnt, s_mcnt);
      end
   endtask

   task automatic test_clear();
      @(negedge clk);
      pred_valid = 1'b1; inst = enc_b(8);
      upd_valid = 1'b1; upd_mispred = 1'b1; clr_stats = 1'b1;
      @(negedge clk);
      pred_valid = 1'b0; upd_valid = 1'b0; upd_mispred = 1'b0;
      clr_stats = 1'b0;
      #1;
      n_checks++;
      if (pcnt !== 32'd0 || mcnt !== 32'd0) begin
         n_fail++; $display("FAIL clear: got %0d/%0d exp 0/0", pcnt, mcnt);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         pred_valid = 1'b1; inst = enc_b(8);
         upd_valid = 1'b1; upd_mispred = 1'b1;
      end
      @(negedge clk);
      pred_valid = 1'b0; upd_valid = 1'b0; upd_mispred = 1'b0;
      #1;
      n_checks++;
      if (pcnt !== 32'd20 || mcnt !== 32'd20) begin
         n_fail++; $display("FAIL count20: got %0d/%0d exp 20/20", pcnt, mcnt);
      end
      n_checks++;
      if (s_pcnt !== 4'd15 || s_mcnt !== 4'd15) begin
         n_fail++;
         $display("FAIL sat15: got %0d/%0d exp 15/15", s_pcnt, s_mcnt);
      end
   endtask

   task automatic test_reset_override();
      @(negedge clk);
      rst = 1'b1; mode = 2'd2; pc = 32'h104; inst = enc_b(8);
      pred_valid = 1'b1; clr_stats = 1'b0;
      upd_valid = 1'b1; upd_addr = 32'h104; upd_idx = 5'd1;
      upd_taken = 1'b0; upd_mispred = 1'b1;
      @(negedge clk);
      rst = 1'b0; pred_valid = 1'b0; upd_valid = 1'b0; upd_mispred = 1'b0;
      #1;
      n_checks++;
      if (pcnt !== 32'd0 || mcnt !== 32'd0) begin
         n_fail++; $display("FAIL rst_ovr_cnt: got %0d/%0d exp 0/0", pcnt, mcnt);
      end
      n_checks++;
      if (result !== 1'b1) begin
         n_fail++; $display("FAIL rst_ovr_bht: got %b exp 1", result);
      end
   endtask

   initial begin
      test_reset();
      test_static();
      test_bimodal();
      test_gshare();
      test_same_cycle();
      test_stats();
      test_clear();
      test_saturate();
      test_reset_override();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
